// File: rtl/lab3_cache_xfer_pkg.sv
// Shared definitions for the cache line transfer engine.
// State encoding, default line size and word address composition.
package lab3_cache_xfer_pkg;

    localparam int XFER_WORDS = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } xfer_state_t;

    // Replace the word-offset field of a line address with a word index.
    function automatic logic [31:0] word_addr(
        input logic [31:0] line,
        input logic [31:0] idx,
        input int          idxw
    );
        logic [31:0] mask;
        mask = ~((32'd1 << (idxw + 2)) - 32'd1);
        return (line & mask) | (idx << 2);
    endfunction

endpackage

// File: rtl/vc_mem_msgs_pkg.sv
// vc memory message formats for the 4-byte memory port.
// Shared by the cache side and the memory side of the system.
package vc_mem_msgs_pkg;

    localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

endpackage

// File: rtl/cache_xfer_line_buf.sv
// WORDS x 32 line buffer: one word write port, full-line read.
// The synchronous clear loads the init line (zero or writeback data).
module cache_xfer_line_buf #(
    parameter  int WORDS = 16,
    localparam int IDXW  = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [32*WORDS-1:0]   init,
    input  logic                  we,
    input  logic [IDXW-1:0]       widx,
    input  logic [31:0]           wdata,
    output logic [32*WORDS-1:0]   line
);

    logic [31:0] mem [WORDS];

    // clear/preload wins over the single-word write port
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= init[32*i +: 32];
            end
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    for (genvar g = 0; g < WORDS; g++) begin : g_rd
        assign line[32*g +: 32] = mem[g];
    end

endmodule

// File: rtl/cache_line_xfer.sv
// Line-to-word burst engine between cache controller and memory.
// LAB3_CACHE_XFER_OOO_EN: place read data by response opaque index.
module cache_line_xfer
    import vc_mem_msgs_pkg::*;
    import lab3_cache_xfer_pkg::*;
#(
    parameter int WORDS = XFER_WORDS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                istream_val,
    output logic                istream_rdy,
    input  logic                istream_rw,
    input  logic [31:0]         istream_addr,
    input  logic [32*WORDS-1:0] istream_wdata,
    output logic                ostream_val,
    input  logic                ostream_rdy,
    output logic [32*WORDS-1:0] ostream_rdata,
    output logic                ostream_rw,
    output logic                cache_req_val,
    input  logic                cache_req_rdy,
    output mem_req_4B_t         cache_req_msg,
    input  logic                cache_resp_val,
    output logic                cache_resp_rdy,
    input  mem_resp_4B_t        cache_resp_msg
);

    localparam int IDXW = $clog2(WORDS);
    localparam int CW   = IDXW + 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    xfer_state_t state, state_nxt;

    logic [CW-1:0]       issue_cnt;
    logic [CW-1:0]       resp_cnt;
    logic                rw_q;
    logic [31:0]         base_q;
    logic [32*WORDS-1:0] line;
    logic [IDXW-1:0]     req_idx;
    logic                accept;
    logic                req_fire;
    logic                resp_fire;
    logic                buf_clr;
    logic                buf_we;
    logic [IDXW-1:0]     buf_widx;
    logic [32*WORDS-1:0] buf_init;
    logic                unused_resp;

    assign accept    = istream_val && istream_rdy;
    assign req_fire  = cache_req_val && cache_req_rdy;
    assign resp_fire = cache_resp_val && cache_resp_rdy;
    assign req_idx   = issue_cnt[IDXW-1:0];

    // next state and handshake outputs; all held low during reset
    always_comb begin
        state_nxt      = state;
        istream_rdy    = 1'b0;
        cache_req_val  = 1'b0;
        cache_resp_rdy = 1'b0;
        ostream_val    = 1'b0;
        if (reset) begin
            unique case (state)
                IDLE: begin
                    istream_rdy = 1'b1;
                    if (istream_val) state_nxt = ISSUE;
                end
                ISSUE: begin
                    cache_req_val  = 1'b1;
                    cache_resp_rdy = 1'b1;
                    if (cache_req_rdy && issue_cnt == LAST) begin
                        if (cache_resp_val && resp_cnt == LAST)
                            state_nxt = DONE;
                        else
                            state_nxt = DRAIN;
                    end
                end
                DRAIN: begin
                    cache_resp_rdy = 1'b1;
                    if (cache_resp_val && resp_cnt == LAST)
                        state_nxt = DONE;
                end
                DONE: begin
                    ostream_val = 1'b1;
                    if (ostream_rdy) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // command latch and issue/response counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            issue_cnt <= '0;
            resp_cnt  <= '0;
            rw_q      <= 1'b0;
            base_q    <= '0;
        end else if (accept) begin
            issue_cnt <= '0;
            resp_cnt  <= '0;
            rw_q      <= istream_rw;
            base_q    <= istream_addr;
        end else begin
            if (req_fire)  issue_cnt <= issue_cnt + CW'(1);
            if (resp_fire) resp_cnt  <= resp_cnt + CW'(1);
        end
    end

    assign buf_clr  = !reset || accept;
    assign buf_init = (reset && istream_rw) ? istream_wdata : '0;
    assign buf_we   = resp_fire && !rw_q;
`ifdef LAB3_CACHE_XFER_OOO_EN
    assign buf_widx = cache_resp_msg.opaque[IDXW-1:0];
`else
    assign buf_widx = resp_cnt[IDXW-1:0];
`endif

    cache_xfer_line_buf #(
        .WORDS (WORDS)
    ) u_buf (
        .clk   (clk),
        .clr   (buf_clr),
        .init  (buf_init),
        .we    (buf_we),
        .widx  (buf_widx),
        .wdata (cache_resp_msg.data),
        .line  (line)
    );

    // request for word issue_cnt, held until its handshake
    always_comb begin
        cache_req_msg        = '0;
        cache_req_msg.type_  = rw_q ? MEM_TYPE_WRITE : MEM_TYPE_READ;
        cache_req_msg.opaque = 8'(req_idx);
        cache_req_msg.addr   = word_addr(base_q, 32'(req_idx), IDXW);
        cache_req_msg.len    = 2'd0;
        cache_req_msg.data   = line[32*req_idx +: 32];
    end

    assign ostream_rdata = line;
    assign ostream_rw    = rw_q;

    assign unused_resp = &{1'b0, cache_resp_msg.type_,
                           cache_resp_msg.opaque,
                           cache_resp_msg.test,
                           cache_resp_msg.len};

endmodule
